// File: rtl/count_bcd_split.sv
// count_bcd_split: frame-synchronous binary-to-BCD converter for the
// seven-segment overlay renderers. A frame_tick captures the count, a
// serial shift-add-3 loop converts it over W cycles, and the digits are
// published in a single update cycle so they never change mid-frame.
// Optional leading-zero mask: define COUNT_BCD_BLANK_EN to drive `blank`;
// otherwise `blank` is tied to zero.
module count_bcd_split #(
  parameter int W    = 30,
  parameter int NDIG = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic [W-1:0]      value,
  output logic [4*NDIG-1:0] digits,
  output logic              valid,
  output logic              busy,
  output logic              update,
  output logic              ovf,
  output logic [NDIG-1:0]   blank
);

  localparam int NINT = (W + 2) / 3;
  // Accumulator is widened so every displayed digit has a nibble even for small W.
  localparam int NACC = (NINT > NDIG) ? NINT : NDIG;
  localparam int AW   = 4 * NACC;
  localparam int CW   = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t              state;
  logic [W-1:0]        shreg;
  logic [AW-1:0]       acc;
  logic [CW-1:0]       cnt;
  logic [AW-1:0]       acc_c;
  logic [4*NDIG-1:0]   dsat;
  logic                ovf_n;

  // Add 3 to every nibble >= 5, all judged on the pre-shift value.
  function automatic logic [AW-1:0] add3(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = a;
    for (int i = 0; i < NACC; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Any nonzero nibble above the displayed digits means the count does not fit.
  function automatic logic high_nz(input logic [AW-1:0] a);
    logic nz;
    nz = 1'b0;
    for (int i = NDIG; i < NACC; i++) begin
      if (a[4*i +: 4] != 4'd0) nz = 1'b1;
    end
    return nz;
  endfunction

  // Saturate to all nines on overflow, otherwise pass the low digits through.
  function automatic logic [4*NDIG-1:0] sat_digits(input logic [AW-1:0] a);
    if (high_nz(a)) return {NDIG{4'h9}};
    return a[4*NDIG-1:0];
  endfunction

  assign acc_c = add3(acc);
  assign dsat  = sat_digits(acc);
  assign ovf_n = high_nz(acc);

  // Capture on tick, iterate W shift-add-3 steps, then publish in LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      valid  <= 1'b0;
      update <= 1'b0;
      ovf    <= 1'b0;
      digits <= '0;
    end else begin
      update <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            shreg <= value;
            acc   <= '0;
            cnt   <= CW'(W);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= {acc_c[AW-2:0], shreg[W-1]};
          shreg <= {shreg[W-2:0], 1'b0};
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= LOAD;
        end
        LOAD: begin
          digits <= dsat;
          ovf    <= ovf_n;
          valid  <= 1'b1;
          update <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COUNT_BCD_BLANK_EN
  // blank[i] set when digit i and every higher digit are zero; digit 0 always shown.
  function automatic logic [NDIG-1:0] lz_mask(input logic [4*NDIG-1:0] d,
                                              input logic ov);
    logic [NDIG-1:0] m;
    logic            z;
    m = '0;
    z = 1'b1;
    if (!ov) begin
      for (int i = NDIG - 1; i >= 1; i--) begin
        z    = z & (d[4*i +: 4] == 4'd0);
        m[i] = z;
      end
    end
    return m;
  endfunction

  // Leading-zero mask is registered alongside the digits it describes.
  always_ff @(posedge clk) begin
    if (reset) blank <= '0;
    else if (state == LOAD) blank <= lz_mask(dsat, ovf_n);
  end
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_count_bcd_split.sv
// Bench for count_bcd_split: a default (W=30, NDIG=10) and an NDIG=4
// instance share stimulus; results are compared against a decimal model.
module tb_count_bcd_split;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [29:0] value;

  logic [39:0] d10;
  logic        valid10, busy10, upd10, ovf10;
  logic [9:0]  blank10;
  logic [15:0] d4;
  logic        valid4, busy4, upd4, ovf4;
  logic [3:0]  blank4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  count_bcd_split #(.W(30), .NDIG(10)) u10 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .value(value),
    .digits(d10), .valid(valid10), .busy(busy10), .update(upd10),
    .ovf(ovf10), .blank(blank10)
  );

  count_bcd_split #(.W(30), .NDIG(4)) u4 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .value(value),
    .digits(d4), .valid(valid4), .busy(busy4), .update(upd4),
    .ovf(ovf4), .blank(blank4)
  );

  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Decimal digits by repeated division; saturate to nines when too large.
  function automatic logic [39:0] model_digits(input longint unsigned v, input int nd);
    logic [39:0] d = '0;
    longint unsigned x = v;
    for (int i = 0; i < nd; i++) begin
      if (v >= pow10(nd)) d[4*i +: 4] = 4'h9;
      else begin
        d[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return d;
  endfunction

  // Digits i and above are all zero exactly when v < 10^i.
  function automatic logic [9:0] model_blank(input longint unsigned v, input int nd);
    logic [9:0] b = '0;
`ifdef COUNT_BCD_BLANK_EN
    if (v < pow10(nd)) begin
      for (int i = 1; i < nd; i++) b[i] = (v < pow10(i));
    end
`endif
    return b;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic [29:0] v);
    @(negedge clk);
    value = v;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic convert(input logic [29:0] v, input logic [39:0] e10,
                         input logic [15:0] e4, input logic eo4);
    int lat, bcnt;
    logic [39:0] dstart;
    logic early;
    tick(v);
    lat = -1; bcnt = 0; dstart = d10; early = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (upd10) begin
        lat = j;
        break;
      end
      if (busy10) bcnt++;
      if (d10 !== dstart) early = 1'b1;
      @(negedge clk);
    end
    chk("latency", lat, 31);
    chk("busy_cycles", bcnt, 31);
    chk("hold_before_update", early, 0);
    chk("digits10", d10, e10);
    chk("digits4", d4, e4);
    chk("ovf4", ovf4, eo4);
    chk("ovf10", ovf10, 0);
    chk("valid", valid10, 1);
    chk("update4", upd4, 1);
    chk("blank10", blank10, model_blank(v, 10));
    chk("blank4", blank4, model_blank(v, 4) & 10'hf);
    @(negedge clk);
    chk("update_single", upd10, 0);
  endtask

  typedef struct {
    logic [29:0] v;
    logic [39:0] e10;
    logic [15:0] e4;
    logic        eo4;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int ups, lat;
    logic [39:0] dcap;
    logic [29:0] rv;
    logic [3:0]  exp_b507;

    tbl[0] = '{30'd0,          40'h0,          16'h0,    1'b0};
    tbl[1] = '{30'd1073741823, 40'h1073741823, 16'h9999, 1'b1};
    tbl[2] = '{30'd12345,      40'h12345,      16'h9999, 1'b1};
    tbl[3] = '{30'd9999,       40'h9999,       16'h9999, 1'b0};
    tbl[4] = '{30'd10000,      40'h10000,      16'h9999, 1'b1};
    tbl[5] = '{30'd999999999,  40'h0999999999, 16'h9999, 1'b1};
    tbl[6] = '{30'd10,         40'h10,         16'h0010, 1'b0};
    tbl[7] = '{30'd507,        40'h507,        16'h0507, 1'b0};

    reset = 1'b1; frame_tick = 1'b0; value = '0;
    repeat (3) @(negedge clk);
    chk("rst_digits", d10, 0);
    chk("rst_valid", valid10, 0);
    chk("rst_busy", busy10, 0);
    chk("rst_update", upd10, 0);
    chk("rst_ovf4", ovf4, 0);
    chk("rst_blank10", blank10, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) convert(tbl[i].v, tbl[i].e10, tbl[i].e4, tbl[i].eo4);

`ifdef COUNT_BCD_BLANK_EN
    exp_b507 = 4'b1000;
`else
    exp_b507 = 4'b0000;
`endif
    chk("blank4_507", blank4, exp_b507);

    // Tick arriving during LOAD is dropped; the next cycle accepts one.
    tick(30'd123);
    repeat (30) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("load_update", upd10, 1);
    chk("load_digits", d10, 40'h123);
    chk("load_tick_ignored", busy10, 0);
    @(negedge clk);
    chk("load_tick_ignored2", busy10, 0);
    convert(30'd456, 40'h456, 16'h0456, 1'b0);

    // Tick while busy is ignored; value changes after capture have no effect.
    tick(30'd250);
    ups = 0; lat = -1; dcap = '0;
    for (int j = 0; j < 50; j++) begin
      if (j == 5) value = 30'd777;
      frame_tick = (j == 10);
      if (upd10) begin
        ups++;
        lat = j;
        dcap = d10;
      end
      @(negedge clk);
    end
    frame_tick = 1'b0;
    chk("busy_tick_updates", ups, 1);
    chk("busy_tick_latency", lat, 31);
    chk("busy_tick_digits", dcap, 40'h250);
    convert(30'd777, 40'h777, 16'h0777, 1'b0);

    // Reset mid-conversion aborts without an update.
    tick(30'd4321);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_digits", d10, 0);
    chk("abort_valid", valid10, 0);
    chk("abort_busy", busy10, 0);
    chk("abort_update", upd10, 0);
    reset = 1'b0;
    ups = 0;
    repeat (40) begin
      @(negedge clk);
      if (upd10) ups++;
    end
    chk("abort_no_update", ups, 0);
    convert(30'd4321, 40'h4321, 16'h4321, 1'b0);

    // Random values against the decimal model.
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) rv = 30'($urandom_range(0, 20000));
      else            rv = 30'($urandom_range(0, 1073741823));
      convert(rv, model_digits(rv, 10), 16'(model_digits(rv, 4)), rv >= 30'd10000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
